multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I datapath, directly upstream of the ALU.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the ALU's 3-bit alu_cntrl plus all datapath mux selects and write enables.
- Consumes the ALU zero flag to resolve beq.
- Supported opcodes: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
- ALU_CW, 3, width of alu_cntrl. Fixed by the ALU; not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address mux: 0=PC, 1=ALU result register
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register and old-PC enable
- result_src  out  2  result mux: 00=ALUOut reg, 01=mem data reg, 10=ALU result direct
- alu_src_a  out  2  ALU A mux: 00=PC, 01=old PC, 10=rs1 reg
- alu_src_b  out  2  ALU B mux: 00=rs2 reg, 01=immediate, 10=constant 4
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- reg_write  out  1  register file write enable
- alu_cntrl  out  3  ALU operation: ADD=000, SUB=001, AND=100, OR=110
- illegal  out  1  one-cycle pulse: unsupported opcode decoded
- state_o  out  4  current state encoding, for debug

Behaviour:
- States and 4-bit codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10
  - Codes 11-15 are unreachable and go to FETCH on the next edge.
- Transitions:
  - FETCH->DECODE always.
  - DECODE on op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH, with illegal=1 during that DECODE cycle
  - MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD->MEMWB.
  - EXECR, EXECI and JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Instruction latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Outputs are Moore-decoded from state. The exceptions are pc_write (uses zero), imm_src (uses op) and alu_cntrl (uses funct fields).
  - Any output not listed for a state is 0.
  - Where a state sets neither alu_src_a/b nor alu_op, both mux selects and alu_op are 00.
- Per-state outputs:
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=ADD, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=ADD (branch target).
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=ADD.
  - MEMREAD: result_src=00, adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=FUNCT.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=FUNCT.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=SUB, result_src=00, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=ADD, result_src=00, pc_update=1.
- pc_write = pc_update | (branch & zero). zero is sampled combinationally within the BEQ cycle.
- alu_cntrl:
  - alu_op ADD -> 000; alu_op SUB -> 001.
  - alu_op FUNCT, decoded on funct3:
    - 000: 001 if op=0110011 and funct7b5=1, else 000 (addi ignores funct7b5)
    - 110: 110
    - 111: 100
    - any other funct3: 000
- imm_src from op: 0100011->01, 1100011->10, 1101111->11, all others 00.
- Reset:
  - A sampled reset=1 loads state=FETCH.
  - While reset=1, pc_write, ir_write, mem_write and reg_write are forced 0 and illegal=0, regardless of state.
  - Reset asserted mid-instruction aborts it; the first cycle after reset deasserts is FETCH with ir_write=1.
  - From a clean reset, all outputs equal FETCH values except the forced-0 enables.

Test Plan:
- reset held 3 cycles in MEMREAD (lw in flight), then released: state_o=0; pc_write=ir_write=reg_write=mem_write=0 during reset; ir_write=1, alu_src_b=10, alu_cntrl=000 on first free cycle.
- lw (op=0000011): state_o sequence 0,1,2,3,4,0; imm_src=00; reg_write=1 only in state 4, with result_src=01.
- R-type sub (op=0110011, funct3=000, funct7b5=1): state 6 shows alu_cntrl=001, alu_src_b=00; ALUWB reg_write=1. Same test with funct3=111 gives alu_cntrl=100; funct3=110 gives 110.
- addi with funct7b5=1 (op=0010011, funct3=000): alu_cntrl=000 in EXECI, alu_src_b=01.
- beq (op=1100011): in state 9, alu_cntrl=001; zero=1 gives pc_write=1, zero=0 gives pc_write=0; next state 0 either way. Total 3 cycles.
- sw: sequence 0,1,2,5,0 with mem_write=1 only in 5, imm_src=01. op=1110011 (unsupported): illegal=1 in DECODE, next state 0, no enables asserted except FETCH ir_write/pc_write.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath: sequences lw/sw/R/I/beq/jal
// through fetch/decode/execute/memory/writeback and drives every datapath control.
module multicycle_ctrl #(
    parameter int ALU_CW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              zero,
    output logic              pc_write,
    output logic              adr_src,
    output logic              mem_write,
    output logic              ir_write,
    output logic [1:0]        result_src,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        imm_src,
    output logic              reg_write,
    output logic [ALU_CW-1:0] alu_cntrl,
    output logic              illegal,
    output logic [3:0]        state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam logic [ALU_CW-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CW-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CW-1:0] ALU_AND = 3'b100;
    localparam logic [ALU_CW-1:0] ALU_OR  = 3'b110;

    state_t  state, state_next;
    alu_op_t alu_op;
    logic    pc_update, branch, illegal_dec;
    logic    ir_write_raw, mem_write_raw, reg_write_raw;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = FETCH;
        alu_op        = OP_ADD;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        adr_src       = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        illegal_dec   = 1'b0;
        case (state)
            FETCH: begin
                state_next   = DECODE;
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_update    = 1'b1;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OPC_LW, OPC_SW: state_next = MEMADR;
                    OPC_R:          state_next = EXECR;
                    OPC_I:          state_next = EXECI;
                    OPC_BEQ:        state_next = BEQ;
                    OPC_JAL:        state_next = JAL;
                    default:        illegal_dec = 1'b1;
                endcase
            end
            MEMADR: begin
                state_next = (op == OPC_LW) ? MEMREAD : MEMWRITE;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
            end
            MEMREAD: begin
                state_next = MEMWB;
                adr_src    = 1'b1;
            end
            MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECR: begin
                state_next = ALUWB;
                alu_src_a  = 2'b10;
                alu_op     = OP_FUNCT;
            end
            EXECI: begin
                state_next = ALUWB;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = OP_FUNCT;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = OP_SUB;
                branch    = 1'b1;
            end
            JAL: begin
                state_next = ALUWB;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // Enables are gated by the live reset input so nothing commits while reset is held.
    assign pc_write  = ~reset & (pc_update | (branch & zero));
    assign ir_write  = ~reset & ir_write_raw;
    assign mem_write = ~reset & mem_write_raw;
    assign reg_write = ~reset & reg_write_raw;
    assign illegal   = ~reset & illegal_dec;
    assign state_o   = state;

    always_comb begin
        alu_cntrl = ALU_ADD;
        case (alu_op)
            OP_SUB: alu_cntrl = ALU_SUB;
            OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_cntrl = (op == OPC_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b110:  alu_cntrl = ALU_OR;
                    3'b111:  alu_cntrl = ALU_AND;
                    default: alu_cntrl = ALU_ADD;
                endcase
            end
            default: alu_cntrl = ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            OPC_SW:  imm_src = 2'b01;
            OPC_BEQ: imm_src = 2'b10;
            OPC_JAL: imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expectations are queued as each
// step is driven and popped/compared mid-cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_cntrl;
    logic [3:0] state_o;

    multicycle_ctrl #(.ALU_CW(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write),
        .alu_cntrl(alu_cntrl), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic       pcw, irw, mw, rw, adr, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] ac;
    } exp_t;

    exp_t       sbq[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [1:0] cur_imm;

    task automatic chk(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] st, input logic pcw, input logic irw,
                        input logic mw, input logic rw, input logic adr, input logic [1:0] rs,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ac,
                        input logic ill);
        exp_t e;
        e.tag = tag; e.st = st; e.pcw = pcw; e.irw = irw; e.mw = mw; e.rw = rw;
        e.adr = adr; e.rs = rs; e.sa = sa; e.sb = sb; e.imm = cur_imm; e.ac = ac; e.ill = ill;
        sbq.push_back(e);
    endtask

    // Compare mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sbq.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sbq.pop_front();
            chk(e.tag, "state", state_o, e.st);
            chk(e.tag, "pc_write", {3'b0, pc_write}, {3'b0, e.pcw});
            chk(e.tag, "ir_write", {3'b0, ir_write}, {3'b0, e.irw});
            chk(e.tag, "mem_write", {3'b0, mem_write}, {3'b0, e.mw});
            chk(e.tag, "reg_write", {3'b0, reg_write}, {3'b0, e.rw});
            chk(e.tag, "adr_src", {3'b0, adr_src}, {3'b0, e.adr});
            chk(e.tag, "result_src", {2'b0, result_src}, {2'b0, e.rs});
            chk(e.tag, "alu_src_a", {2'b0, alu_src_a}, {2'b0, e.sa});
            chk(e.tag, "alu_src_b", {2'b0, alu_src_b}, {2'b0, e.sb});
            chk(e.tag, "imm_src", {2'b0, imm_src}, {2'b0, e.imm});
            chk(e.tag, "alu_cntrl", {1'b0, alu_cntrl}, {1'b0, e.ac});
            chk(e.tag, "illegal", {3'b0, illegal}, {3'b0, e.ill});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [1:0] imm);
        op = o; funct3 = f3; funct7b5 = f7; cur_imm = imm;
    endtask

    // One task per state; each expected row is written out from the state's output list.
    task automatic s_fetch(input string t, input logic en);
        push(t, 4'd0, en, en, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0); tick();
    endtask
    task automatic s_decode(input string t, input logic ill);
        push(t, 4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, ill); tick();
    endtask
    task automatic s_memadr(input string t);
        push(t, 4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0); tick();
    endtask
    task automatic s_memread(input string t);
        push(t, 4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0); tick();
    endtask
    task automatic s_memwb(input string t);
        push(t, 4'd4, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3'b000, 0); tick();
    endtask
    task automatic s_memwrite(input string t);
        push(t, 4'd5, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0); tick();
    endtask
    task automatic s_execr(input string t, input logic [2:0] ac);
        push(t, 4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ac, 0); tick();
    endtask
    task automatic s_execi(input string t, input logic [2:0] ac);
        push(t, 4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ac, 0); tick();
    endtask
    task automatic s_aluwb(input string t);
        push(t, 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0); tick();
    endtask
    task automatic s_beq(input string t, input logic z);
        zero = z;
        push(t, 4'd9, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0); tick();
        zero = 1'b0;
    endtask
    task automatic s_jal(input string t);
        push(t, 4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0); tick();
    endtask

    initial begin
        reset = 1'b1; zero = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
        @(posedge clk); #1;
        s_fetch("rst_clean", 0);
        reset = 1'b0;

        s_fetch("lw_f", 1); s_decode("lw_d", 0); s_memadr("lw_a");
        s_memread("lw_r"); s_memwb("lw_wb");

        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        s_fetch("sw_f", 1); s_decode("sw_d", 0); s_memadr("sw_a"); s_memwrite("sw_w");

        // lw in flight, reset held for three sampled edges starting in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
        s_fetch("rlw_f", 1); s_decode("rlw_d", 0); s_memadr("rlw_a");
        reset = 1'b1;
        s_memread("rst_mr"); s_fetch("rst_f1", 0); s_fetch("rst_f2", 0);
        reset = 1'b0;
        s_fetch("rst_free", 1);
        s_decode("rlw_d2", 0); s_memadr("rlw_a2"); s_memread("rlw_r2"); s_memwb("rlw_wb2");

        set_instr(7'b0110011, 3'b000, 1'b1, 2'b00);
        s_fetch("sub_f", 1); s_decode("sub_d", 0); s_execr("sub_x", 3'b001); s_aluwb("sub_wb");
        set_instr(7'b0110011, 3'b000, 1'b0, 2'b00);
        s_fetch("add_f", 1); s_decode("add_d", 0); s_execr("add_x", 3'b000); s_aluwb("add_wb");
        set_instr(7'b0110011, 3'b111, 1'b0, 2'b00);
        s_fetch("and_f", 1); s_decode("and_d", 0); s_execr("and_x", 3'b100); s_aluwb("and_wb");
        set_instr(7'b0110011, 3'b110, 1'b0, 2'b00);
        s_fetch("or_f", 1); s_decode("or_d", 0); s_execr("or_x", 3'b110); s_aluwb("or_wb");
        set_instr(7'b0110011, 3'b010, 1'b0, 2'b00);
        s_fetch("slt_f", 1); s_decode("slt_d", 0); s_execr("slt_x", 3'b000); s_aluwb("slt_wb");

        set_instr(7'b0010011, 3'b000, 1'b1, 2'b00);
        s_fetch("addi_f", 1); s_decode("addi_d", 0); s_execi("addi_x", 3'b000); s_aluwb("addi_wb");
        set_instr(7'b0010011, 3'b110, 1'b0, 2'b00);
        s_fetch("ori_f", 1); s_decode("ori_d", 0); s_execi("ori_x", 3'b110); s_aluwb("ori_wb");

        set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
        s_fetch("beqt_f", 1); s_decode("beqt_d", 0); s_beq("beqt_x", 1'b1);
        s_fetch("beqn_f", 1); s_decode("beqn_d", 0); s_beq("beqn_x", 1'b0);

        set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
        s_fetch("jal_f", 1); s_decode("jal_d", 0); s_jal("jal_x"); s_aluwb("jal_wb");

        set_instr(7'b1110011, 3'b000, 1'b0, 2'b00);
        s_fetch("ill_f", 1); s_decode("ill_d", 1);
        s_fetch("ill_next", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
